imem_axi_responder: RTL

- AXI4-Lite read-only responder for instruction memory: the slave end of the read channel that the fetch stage drives.
- Holds a word-addressed synchronous RAM of 2^ADDR_WIDTH 32-bit words and answers AR requests with R beats in order.
- Supports a configurable number of outstanding requests and backpressure on R.
- A side write port lets a loader or debug unit fill the memory.

---
 rtl/imem_axi_responder_if.sv | 21 ++
 rtl/imem_axi_responder.sv | 98 +++++++++
 2 files changed

// File: rtl/imem_axi_responder_if.sv
// AXI4-Lite read channel (AR + R) between an instruction-fetch master and the imem responder.
interface imem_axi_responder_if;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/imem_axi_responder.sv
// Read-only AXI4-Lite instruction memory: synchronous word RAM feeding an in-order response FIFO,
// with a byte-strobed side write port for loading.
module imem_axi_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_axi_responder_if.slave   bus,
  input  logic                  load_wena,
  input  logic [ADDR_WIDTH-1:0] load_waddr,
  input  logic [31:0]           load_wdata,
  input  logic [3:0]            load_wstrb
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } entry_t;

  logic [31:0]           mem [WORDS];
  entry_t                fifo [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] index;
  logic                  full;
  logic                  rvalid;
  logic                  push;
  logic                  pop;
  logic                  unused;

  // Window decode: offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
  assign offset   = bus.araddr - BASE_ADDR;
  assign in_range = (offset[31:ADDR_WIDTH+2] == '0) && (bus.araddr[1:0] == 2'b00);
  assign index    = offset[ADDR_WIDTH+1:2];
  assign unused   = ^{bus.arprot, offset[1:0]};

  assign full   = (count == CNT_W'(DEPTH));
  assign rvalid = (count != '0);
  assign pop    = rvalid && bus.rready;
  // A full FIFO still accepts when the head leaves this cycle, giving full throughput at DEPTH=1.
  assign bus.arready = !reset && (!full || pop);
  assign push        = bus.arvalid && bus.arready;

  assign bus.rvalid = rvalid;
  assign bus.rdata  = rvalid ? fifo[rd_ptr].data : '0;
  assign bus.rresp  = rvalid ? fifo[rd_ptr].resp : RESP_OKAY;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Memory read lands directly in the FIFO tail; same-edge loader writes are not yet visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr].data <= in_range ? mem[index] : 32'h0;
      fifo[wr_ptr].resp <= in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Loader byte-strobed write port.
  always_ff @(posedge clk) begin
    if (load_wena) begin
      for (int b = 0; b < 4; b++) begin
        if (load_wstrb[b]) mem[load_waddr][8*b +: 8] <= load_wdata[8*b +: 8];
      end
    end
  end

endmodule
